// File: rtl/comp16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// comp16_rr_arbiter
//
// Shares a single 16-bit unsigned magnitude comparator between N_REQ
// requesters in the reservoir readout path. A round-robin arbiter picks one
// pending requester and latches its operand pair. The shared comparator then
// evaluates the pair, and the result is returned as registered lt/gt/eq flags
// together with a one-cycle done pulse to the winner.
//
// Each operation takes three cycles: IDLE -> CMP -> DONE -> IDLE.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [N_REQ]        level requests, held until done
//   a_flat     in   [N_REQ*WIDTH]  operand A of requester i at [i*WIDTH +: WIDTH]
//   b_flat     in   [N_REQ*WIDTH]  operand B of requester i, same packing
//   grant      out  [N_REQ]        one-hot winner during CMP and DONE
//   done       out  [N_REQ]        one-hot single-cycle result-valid pulse
//   lt_out     out  A <  B of the last completed compare
//   gt_out     out  A >  B of the last completed compare
//   eq_out     out  A == B of the last completed compare (1 after reset)
//   winner_idx out  [IDX_W]        index of the current or last winner
//   busy       out  high in CMP and DONE
// ---------------------------------------------------------------------------

// Comparator slice chain: four 4-bit stages cascaded from the least
// significant nibble upward. A stage whose nibbles are equal passes through
// the verdict of the stage below it. The lowest stage takes the external seed.
module comp_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        lt_in,
  input  logic        gt_in,
  input  logic        eq_in,
  output logic        lt,
  output logic        gt,
  output logic        eq
);

  // One nibble stage; the result is packed as {lt, gt, eq}.
  function automatic logic [2:0] cmp4(input logic [3:0] an, input logic [3:0] bn,
                                      input logic [2:0] casc);
    if (an > bn) begin
      cmp4 = 3'b010;
    end else if (an < bn) begin
      cmp4 = 3'b100;
    end else begin
      cmp4 = casc;
    end
  endfunction

  logic [2:0] c0_s;
  logic [2:0] c1_s;
  logic [2:0] c2_s;
  logic [2:0] c3_s;

  // Ripple the verdict from the low nibble to the high nibble.
  always_comb begin
    c0_s = cmp4(a[3:0],   b[3:0],   {lt_in, gt_in, eq_in});
    c1_s = cmp4(a[7:4],   b[7:4],   c0_s);
    c2_s = cmp4(a[11:8],  b[11:8],  c1_s);
    c3_s = cmp4(a[15:12], b[15:12], c2_s);
    lt   = c3_s[2];
    gt   = c3_s[1];
    eq   = c3_s[0];
  end

endmodule

module comp16_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_flat,
  input  logic [N_REQ*WIDTH-1:0]   b_flat,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     lt_out,
  output logic                     gt_out,
  output logic                     eq_out,
  output logic [IDX_W-1:0]         winner_idx,
  output logic                     busy
);

  localparam int                IW1      = IDX_W + 1;
  localparam logic [IDX_W:0]    N_REQ_V  = IW1'(N_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reduce an index sum (at most 2*N_REQ-2) modulo N_REQ.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] s);
    if (s >= N_REQ_V) begin
      wrap_idx = IDX_W'(s - N_REQ_V);
    end else begin
      wrap_idx = s[IDX_W-1:0];
    end
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = {N_REQ{1'b0}};
    onehot[idx] = 1'b1;
  endfunction

  // Registered state
  state_t             state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [N_REQ-1:0]   grant_r;
  logic [N_REQ-1:0]   done_r;
  logic               lt_r;
  logic               gt_r;
  logic               eq_r;
  logic [IDX_W-1:0]   winner_r;
  logic               busy_r;

  // Next-state values
  state_t             state_s;
  logic [IDX_W-1:0]   rr_ptr_s;
  logic [WIDTH-1:0]   op_a_s;
  logic [WIDTH-1:0]   op_b_s;
  logic [N_REQ-1:0]   grant_s;
  logic [N_REQ-1:0]   done_s;
  logic               lt_s;
  logic               gt_s;
  logic               eq_s;
  logic [IDX_W-1:0]   winner_s;
  logic               busy_s;

  // Arbitration and comparator nets
  logic [WIDTH-1:0]   a_arr [N_REQ];
  logic [WIDTH-1:0]   b_arr [N_REQ];
  logic [N_REQ-1:0]   rot_s;
  logic [IDX_W-1:0]   off_s;
  logic [IDX_W-1:0]   pick_s;
  logic               any_req_s;
  logic               cmp_lt_s;
  logic               cmp_gt_s;
  logic               cmp_eq_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = a_flat[g*WIDTH +: WIDTH];
    assign b_arr[g] = b_flat[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: rotate req so that bit 0 is rr_ptr, then take the lowest
  // set bit and rotate the offset back to an absolute requester index.
  always_comb begin
    rot_s = {N_REQ{1'b0}};
    off_s = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      rot_s[IDX_W'(i)] = req[wrap_idx({1'b0, rr_ptr_r} + IW1'(i))];
    end
    // Scan high to low so that the lowest set offset is the one kept.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      off_s = rot_s[IDX_W'(i)] ? IDX_W'(i) : off_s;
    end
    pick_s    = wrap_idx({1'b0, rr_ptr_r} + {1'b0, off_s});
    any_req_s = |req;
  end

  // The comparator only ever sees the latched operands, with the equal seed.
  comp_16bit u_cmp (
    .a     (op_a_r),
    .b     (op_b_r),
    .lt_in (1'b0),
    .gt_in (1'b0),
    .eq_in (1'b1),
    .lt    (cmp_lt_s),
    .gt    (cmp_gt_s),
    .eq    (cmp_eq_s)
  );

  // FSM next state and next values for all registered outputs.
  always_comb begin
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    op_a_s   = op_a_r;
    op_b_s   = op_b_r;
    grant_s  = grant_r;
    done_s   = done_r;
    lt_s     = lt_r;
    gt_s     = gt_r;
    eq_s     = eq_r;
    winner_s = winner_r;
    busy_s   = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s  = ST_CMP;
          op_a_s   = a_arr[pick_s];
          op_b_s   = b_arr[pick_s];
          winner_s = pick_s;
          grant_s  = onehot(pick_s);
          done_s   = {N_REQ{1'b0}};
          busy_s   = 1'b1;
        end else begin
          state_s  = ST_IDLE;
          grant_s  = {N_REQ{1'b0}};
          done_s   = {N_REQ{1'b0}};
          busy_s   = 1'b0;
        end
      end
      ST_CMP: begin
        state_s = ST_DONE;
        lt_s    = cmp_lt_s;
        gt_s    = cmp_gt_s;
        eq_s    = cmp_eq_s;
        done_s  = onehot(winner_r);
      end
      ST_DONE: begin
        state_s  = ST_IDLE;
        done_s   = {N_REQ{1'b0}};
        grant_s  = {N_REQ{1'b0}};
        busy_s   = 1'b0;
        // The pointer moves just past the winner, so every other pending
        // requester is served before this one can win again.
        rr_ptr_s = (winner_r == LAST_IDX) ? {IDX_W{1'b0}} : winner_r + IDX_ONE;
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = {N_REQ{1'b0}};
        done_s  = {N_REQ{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; a reset mid-operation drops the compare silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= {IDX_W{1'b0}};
      op_a_r   <= {WIDTH{1'b0}};
      op_b_r   <= {WIDTH{1'b0}};
      grant_r  <= {N_REQ{1'b0}};
      done_r   <= {N_REQ{1'b0}};
      lt_r     <= 1'b0;
      gt_r     <= 1'b0;
      eq_r     <= 1'b1;
      winner_r <= {IDX_W{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      rr_ptr_r <= rr_ptr_s;
      op_a_r   <= op_a_s;
      op_b_r   <= op_b_s;
      grant_r  <= grant_s;
      done_r   <= done_s;
      lt_r     <= lt_s;
      gt_r     <= gt_s;
      eq_r     <= eq_s;
      winner_r <= winner_s;
      busy_r   <= busy_s;
    end
  end

  assign grant      = grant_r;
  assign done       = done_r;
  assign lt_out     = lt_r;
  assign gt_out     = gt_r;
  assign eq_out     = eq_r;
  assign winner_idx = winner_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_comp16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_comp16_rr_arbiter
//
// Directed bench for comp16_rr_arbiter with N_REQ=4. At each arbitration
// edge the bench predicts the winner and the lt/gt/eq result from its own
// round-robin pointer and plain integer comparison, and pushes that
// prediction onto a scoreboard queue. The entry is popped and compared when
// the done pulse appears.
// ---------------------------------------------------------------------------
module tb_comp16_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 16;
  localparam int IDX_W = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_flat;
  logic [N_REQ*WIDTH-1:0] b_flat;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   lt_out;
  logic                   gt_out;
  logic                   eq_out;
  logic [IDX_W-1:0]       winner_idx;
  logic                   busy;

  typedef struct packed {
    logic [1:0] w;
    logic       lt;
    logic       gt;
    logic       eq;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ptr_m    = 0;

  comp16_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .grant      (grant),
    .done       (done),
    .lt_out     (lt_out),
    .gt_out     (gt_out),
    .eq_out     (eq_out),
    .winner_idx (winner_idx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N_REQ; i++) begin
      if (r[(p + i) % N_REQ]) return (p + i) % N_REQ;
    end
    return 0;
  endfunction

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    a_flat[i*WIDTH +: WIDTH] = a;
    b_flat[i*WIDTH +: WIDTH] = b;
  endtask

  // Predict and push, then step over the arbitration edge and check the grant.
  task automatic arb_step(input string tag);
    exp_t        e;
    int          w;
    logic [15:0] ea;
    logic [15:0] eb;
    w    = pick(req, ptr_m);
    ea   = a_flat[w*WIDTH +: WIDTH];
    eb   = b_flat[w*WIDTH +: WIDTH];
    e.w  = w[1:0];
    e.lt = (ea < eb);
    e.gt = (ea > eb);
    e.eq = (ea == eb);
    sb_q.push_back(e);
    @(posedge clk); #1;
    check({tag, " grant"},      32'(grant),      32'(4'b0001 << w));
    check({tag, " winner_idx"}, 32'(winner_idx), w);
    check({tag, " busy"},       32'(busy),       32'd1);
    check({tag, " done_early"}, 32'(done),       32'd0);
  endtask

  // Result edge: pop the prediction and compare it; then check the release edge.
  task automatic result_step(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e = '0;
    end
    check({tag, " done"}, 32'(done),   32'(4'b0001 << e.w));
    check({tag, " lt"},   32'(lt_out), 32'(e.lt));
    check({tag, " gt"},   32'(gt_out), 32'(e.gt));
    check({tag, " eq"},   32'(eq_out), 32'(e.eq));
    @(posedge clk); #1;
    check({tag, " done_clr"},  32'(done),  32'd0);
    check({tag, " grant_clr"}, 32'(grant), 32'd0);
    check({tag, " busy_clr"},  32'(busy),  32'd0);
    ptr_m = (int'(e.w) + 1) % N_REQ;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 4'b0000;
    a_flat = 64'd0;
    b_flat = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst grant",  32'(grant),      32'd0);
    check("rst done",   32'(done),       32'd0);
    check("rst busy",   32'(busy),       32'd0);
    check("rst widx",   32'(winner_idx), 32'd0);
    check("rst lt",     32'(lt_out),     32'd0);
    check("rst gt",     32'(gt_out),     32'd0);
    check("rst eq",     32'(eq_out),     32'd1);
    rst_n = 1'b1;

    // Single request, equal operands.
    req = 4'b0001;
    set_ops(0, 16'h1234, 16'h1234);
    arb_step("single_eq");
    result_step("single_eq");
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("idle busy",  32'(busy),  32'd0);
    check("idle grant", 32'(grant), 32'd0);

    // High-nibble dominance in both directions.
    req = 4'b0100;
    set_ops(2, 16'h8000, 16'h7FFF);
    arb_step("msb_gt");
    result_step("msb_gt");
    set_ops(2, 16'h0001, 16'hF000);
    arb_step("msb_lt");
    result_step("msb_lt");
    req = 4'b0000;

    // Fairness and wrap, starting from a fresh reset.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr_m = 0;
    set_ops(0, 16'h0000, 16'hFFFF);
    set_ops(1, 16'hFFFF, 16'h0000);
    set_ops(2, 16'hA5A5, 16'hA5A5);
    set_ops(3, 16'h00FF, 16'h0100);
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      if (s == 4) set_ops(0, 16'hFFFF, 16'hFFFF);
      arb_step($sformatf("fair%0d", s));
      result_step($sformatf("fair%0d", s));
    end

    // Priority after serving requester 1: the pointer sits at 2, so 0 wins by wrap.
    req = 4'b0010;
    set_ops(1, 16'h0010, 16'h0010);
    arb_step("serve1");
    result_step("serve1");
    req = 4'b0011;
    set_ops(0, 16'h4000, 16'h3FFF);
    set_ops(1, 16'h0002, 16'h0003);
    arb_step("wrap0");
    result_step("wrap0");
    arb_step("then1");
    result_step("then1");

    // Request dropped and operand changed while the compare is in flight.
    req = 4'b0010;
    set_ops(1, 16'h0005, 16'h0009);
    arb_step("drop");
    req = 4'b0000;
    set_ops(1, 16'hFFFF, 16'h0000);
    result_step("drop");

    // Reset in the middle of a compare: serve 0 first so the pointer sits at 1.
    req = 4'b0001;
    set_ops(0, 16'h0100, 16'h0200);
    arb_step("pre_rst");
    result_step("pre_rst");
    req = 4'b0011;
    set_ops(1, 16'h0300, 16'h0001);
    arb_step("abort");
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    check("abort grant", 32'(grant),  32'd0);
    check("abort done",  32'(done),   32'd0);
    check("abort busy",  32'(busy),   32'd0);
    check("abort eq",    32'(eq_out), 32'd1);
    check("abort lt",    32'(lt_out), 32'd0);
    check("abort gt",    32'(gt_out), 32'd0);
    @(posedge clk); #1;
    check("abort no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    ptr_m = 0;
    set_ops(0, 16'h7777, 16'h7776);
    arb_step("post_rst");
    result_step("post_rst");
    req = 4'b0000;
    check("sb empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comp16_rr_arbiter.md
Name: comp16_rr_arbiter

Overview:
- Shares one 16-bit unsigned magnitude comparator (comp_16bit, instantiated internally) between N_REQ requesters in the reservoir readout path.
- Arbitration is round-robin. Each granted requester's operand pair is latched, compared and returned as registered lt/gt/eq flags with a one-cycle done pulse.
- Sits between the neuron-state compare clients (threshold / winner-take-all units) and the single comparator instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width (fixed at 16; matches comparator)
- IDX_W, 2, index width, must be ceil(log2(N_REQ))

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester compare request, level, held until done
- a_flat  in  N_REQ*WIDTH  operand A of requester i at [i*WIDTH +: WIDTH]
- b_flat  in  N_REQ*WIDTH  operand B of requester i, same packing
- grant  out  N_REQ  one-hot, registered; high for the winner during CMP and DONE
- done  out  N_REQ  one-hot, registered, single-cycle pulse when the winner's result is valid
- lt_out  out  1  registered result, A<B, held until the next DONE
- gt_out  out  1  registered result, A>B
- eq_out  out  1  registered result, A==B
- winner_idx  out  IDX_W  index of the current or last winner
- busy  out  1  high in CMP and DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, grant=0, done=0, winner_idx=0, busy=0
  - lt_out=0, gt_out=0, eq_out=1 (equal seed)
  - Operand registers cleared to 0.
- FSM states: IDLE -> CMP -> DONE -> IDLE. No other transitions.
- IDLE:
  - If req==0, stay.
  - Otherwise select the first set req bit, scanning from rr_ptr upward and wrapping modulo N_REQ.
  - At the clock edge: latch the winner's A/B into op_a/op_b, set winner_idx, grant=onehot(winner), busy=1, go CMP.
- CMP:
  - Comparator sees op_a/op_b. It is cascaded with seed lt=0, gt=0, eq=1 and is purely combinational.
  - At the edge: capture lt/gt/eq into the outputs, done=onehot(winner), go DONE.
- DONE:
  - done is high this cycle only.
  - At the edge: done=0, grant=0, busy=0, rr_ptr=(winner+1) mod N_REQ, go IDLE.
- Latency: req high before edge k -> grant visible after edge k, results and done visible after edge k+1, done cleared after edge k+2.
- Throughput: one compare per 3 cycles. The next arbitration happens at edge k+3.
- Operand sampling: operands are read only at the IDLE->CMP edge. Changes afterwards do not affect the result.
- Req dropped in CMP/DONE: the operation still completes and done still pulses. The requester must ignore the pulse if uninterested.
- Req held after its done: the requester is re-eligible, but round-robin gives every other pending requester priority first.
- Simultaneous requests: exactly one grant. A pending requester waits at most N_REQ-1 other services.
- rr_ptr wraps from N_REQ-1 to 0.
- Comparison is unsigned over all 16 bits. Exactly one of lt/gt/eq is 1 after any completed compare.
- Reset asserted mid-operation: immediate return to reset values. No done is issued for the aborted compare.
- done and grant are never high for two requesters at once.

Test Plan:
- Single request, equal: req=0001, A0=B0=0x1234 -> grant=0001 next cycle; one cycle later done=0001 with eq=1, lt=0, gt=0; done low the following cycle.
- High-nibble dominance: req=0100, A2=0x8000, B2=0x7FFF -> gt=1; then A2=0x0001, B2=0xF000 -> lt=1.
- Fairness and wrap: req=1111 held from reset -> winners 0,1,2,3,0 on successive 3-cycle slots; winner_idx matches; grant always one-hot.
- Priority after service: rr_ptr at 2 (after serving 1), req=0011 -> requester 0 wins (wrap), then 1.
- Drop and operand change mid-op: req1 drops and A1 changes in CMP -> done=0010 still pulses with the result of the latched operands.
- Reset mid-op: rst_n low during CMP -> outputs immediately grant=0, done=0, eq_out=1, busy=0. After release with req=0001, the first winner is requester 0.
